// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
//   Write-back controller for the 32 x XLEN register file. The single write
//   port is shared among NREQ write-back sources with round-robin arbitration.
//   A pending-write scoreboard makes decode stall on RAW/WAW hazards until
//   the producing write has landed in the register file.
//
// Handshake: a requester raises req_valid[i] and holds req_valid, req_rd and
//   req_data stable until req_ready[i] is seen. A transfer happens on the
//   clock edge where req_valid[i] & req_ready[i]. req_ready is purely
//   combinational from req_valid and the round-robin pointer. It never
//   depends on next-cycle state.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   iss_en            decode issues an instruction this cycle
//   iss_rd/rs1/rs2    destination / sources of the instruction in decode
//   iss_stall         decode must hold (hazard on rs1, rs2 or rd)
//   flush             drop all pending marks
//   req_valid         per-requester write-back valid
//   req_rd            per-requester destination, req i at [5i+4:5i]
//   req_data          per-requester result, req i at [XLEN*i +: XLEN]
//   req_ready         one-hot grant
//   rf_rd_en/addr/data register file write port
//   pending           scoreboard bitmap (bit 0 always 0)
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_en,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           iss_rs1,
  input  logic [4:0]           iss_rs2,
  output logic                 iss_stall,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_rd_en,
  output logic [4:0]           rf_rd_addr,
  output logic [XLEN-1:0]      rf_rd_data,
  output logic [31:0]          pending
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr, rr_next;
  logic [PW-1:0] win, win_hi, win_lo;
  logic          any_hi, any_lo, grant;
  logic [31:0]   pending_q, pending_d;
  logic          hazard, issue;

  // Round-robin search: the lowest valid index at or above rr_ptr wins,
  // otherwise wrap around to the lowest valid index overall. Descending
  // loops let the lowest index overwrite the higher ones.
  always_comb begin
    any_hi = 1'b0;
    any_lo = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        any_lo = 1'b1;
        win_lo = PW'(j);
        if (PW'(j) >= rr_ptr) begin
          any_hi = 1'b1;
          win_hi = PW'(j);
        end
      end
    end
    win   = any_hi ? win_hi : win_lo;
    // Grant is gated by rst_n so an asserted reset drops it immediately,
    // even while requesters still hold valid.
    grant = any_lo & rst_n;
  end

  // Winner mux: one-hot ready plus the write port, all zero with no grant.
  always_comb begin
    req_ready  = '0;
    rf_rd_addr = '0;
    rf_rd_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant && (win == PW'(j))) begin
        req_ready[j] = 1'b1;
        rf_rd_addr   = req_rd[5*j +: 5];
        rf_rd_data   = req_data[XLEN*j +: XLEN];
      end
    end
    // A write to x0 completes the handshake but never reaches the file.
    rf_rd_en = grant & (rf_rd_addr != 5'd0);
  end

  always_comb begin
    rr_next = rr_ptr;
    if (grant) begin
      rr_next = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end

  // Scoreboard. Ordering matters: clear first, so a same-edge set of the
  // same index wins, and flush last, so it overrides both.
  always_comb begin
    hazard = ((iss_rs1 != 5'd0) & pending_q[iss_rs1]) |
             ((iss_rs2 != 5'd0) & pending_q[iss_rs2]) |
             ((iss_rd  != 5'd0) & pending_q[iss_rd]);
    issue  = iss_en & ~hazard;

    pending_d = pending_q;
    if (rf_rd_en) begin
      pending_d[rf_rd_addr] = 1'b0;
    end
    if (issue && (iss_rd != 5'd0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      pending_d = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rr_ptr    <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr    <= rr_next;
    end
  end

  assign iss_stall = hazard;
  assign pending   = pending_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_ctrl
//   Scenario tasks drive inputs one time unit after the rising edge and check
//   combinational outputs shortly after. Every register-file write the DUT
//   performs is compared at the falling edge against an expected queue that
//   the scenario tasks fill when they drive a write-back.
// ---------------------------------------------------------------------------
module tb_regfile_wb_ctrl;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  logic                 clk;
  logic                 rst_n;
  logic                 iss_en;
  logic [4:0]           iss_rd, iss_rs1, iss_rs2;
  logic                 iss_stall;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_rd_en;
  logic [4:0]           rf_rd_addr;
  logic [XLEN-1:0]      rf_rd_data;
  logic [31:0]          pending;

  int n_vec  = 0;
  int n_miss = 0;

  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  regfile_wb_ctrl #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_en     (iss_en),
    .iss_rd     (iss_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_stall  (iss_stall),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .pending    (pending)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    iss_en    = 1'b0;
    iss_rd    = '0;
    iss_rs1   = '0;
    iss_rs2   = '0;
    flush     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                         input logic [31:0] d);
    req_valid[i]         = v;
    req_rd[5*i +: 5]     = rd;
    req_data[32*i +: 32] = d;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rf_rd_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL wb_unexpected: got addr=%0d data=%h, expected no write",
                 rf_rd_addr, rf_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_rd_addr, rf_rd_data} !== mon_e) begin
          n_miss++;
          $display("FAIL wb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_rd_addr, rf_rd_data, mon_e[36:32], mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    n_vec++;
    if ({req_ready, rf_rd_en, pending, iss_stall} !== {3'b000, 1'b0, 32'h0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_state: ready=%b en=%b pending=%h stall=%b, expected all 0",
               req_ready, rf_rd_en, pending, iss_stall);
    end
    cyc();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, rf_rd_en, pending, iss_stall} !== {3'b000, 1'b0, 32'h0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_idle: ready=%b en=%b pending=%h stall=%b, expected all 0",
               req_ready, rf_rd_en, pending, iss_stall);
    end
  endtask

  task automatic test_raw_stall();
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd5;
    #1;
    n_vec++;
    if (iss_stall !== 1'b0) begin
      n_miss++;
      $display("FAIL raw_first_issue: stall=%b, expected 0", iss_stall);
    end
    cyc();
    // Stalled issue of rd=6 reading x5 must not mark x6.
    iss_en = 1'b1; iss_rd = 5'd6; iss_rs1 = 5'd5;
    #1;
    n_vec++;
    if ({iss_stall, pending} !== {1'b1, 32'h0000_0020}) begin
      n_miss++;
      $display("FAIL raw_stall: stall=%b pending=%h, expected 1 00000020", iss_stall, pending);
    end
    cyc();
    n_vec++;
    if ({iss_stall, pending} !== {1'b1, 32'h0000_0020}) begin
      n_miss++;
      $display("FAIL raw_stall_hold: stall=%b pending=%h, expected 1 00000020",
               iss_stall, pending);
    end
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    #1;
    n_vec++;
    if ({req_ready, rf_rd_en, rf_rd_addr, rf_rd_data, iss_stall} !==
        {3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1}) begin
      n_miss++;
      $display("FAIL raw_wb_grant: ready=%b en=%b addr=%0d data=%h stall=%b, expected 001 1 5 deadbeef 1",
               req_ready, rf_rd_en, rf_rd_addr, rf_rd_data, iss_stall);
    end
    cyc();
    set_req(0, 1'b0, 5'd0, 32'h0);
    iss_en = 1'b0;
    #1;
    n_vec++;
    if ({iss_stall, pending} !== {1'b0, 32'h0}) begin
      n_miss++;
      $display("FAIL raw_release: stall=%b pending=%h, expected 0 00000000", iss_stall, pending);
    end
    idle();
  endtask

  task automatic test_round_robin();
    logic [31:0] d3[3];
    logic [4:0]  r3[3];
    int w;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      r3[i] = 5'(10 + i);
      d3[i] = $urandom;
      set_req(i, 1'b1, r3[i], d3[i]);
    end
    for (int c = 0; c < 6; c++) begin
      w = c % NREQ;
      #1;
      n_vec++;
      if (req_ready !== (3'b001 << w)) begin
        n_miss++;
        $display("FAIL rr_grant[%0d]: ready=%b, expected %b", c, req_ready, 3'b001 << w);
      end
      exp_q.push_back({r3[w], d3[w]});
      cyc();
      d3[w] = $urandom;
      set_req(w, 1'b1, r3[w], d3[w]);
    end
    idle();
  endtask

  task automatic test_x0_write();
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd3;
    cyc();
    iss_en = 1'b0; iss_rd = 5'd0;
    set_req(0, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    n_vec++;
    if ({req_ready, rf_rd_en} !== {3'b001, 1'b0}) begin
      n_miss++;
      $display("FAIL x0_grant: ready=%b en=%b, expected 001 0", req_ready, rf_rd_en);
    end
    cyc();
    idle();
    #1;
    n_vec++;
    if (pending !== 32'h0000_0008) begin
      n_miss++;
      $display("FAIL x0_pending: pending=%h, expected 00000008", pending);
    end
  endtask

  task automatic test_set_clear_same_edge();
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd7;
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    exp_q.push_back({5'd7, 32'h0000_0077});
    #1;
    n_vec++;
    if ({iss_stall, rf_rd_en} !== {1'b0, 1'b1}) begin
      n_miss++;
      $display("FAIL same_edge_inputs: stall=%b en=%b, expected 0 1", iss_stall, rf_rd_en);
    end
    cyc();
    idle();
    #1;
    n_vec++;
    if (pending !== 32'h0000_0080) begin
      n_miss++;
      $display("FAIL same_edge_set_wins: pending=%h, expected 00000080", pending);
    end
  endtask

  task automatic test_flush_and_async_reset();
    do_reset();
    iss_en = 1'b1; iss_rd = 5'd3;
    cyc();
    iss_rd = 5'd9;
    cyc();
    iss_en = 1'b0;
    #1;
    n_vec++;
    if (pending !== 32'h0000_0208) begin
      n_miss++;
      $display("FAIL flush_setup: pending=%h, expected 00000208", pending);
    end
    // Flush together with an issue: nothing may survive.
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd12;
    cyc();
    flush = 1'b0; iss_en = 1'b0; iss_rd = 5'd0;
    #1;
    n_vec++;
    if (pending !== 32'h0) begin
      n_miss++;
      $display("FAIL flush_clear: pending=%h, expected 00000000", pending);
    end
    set_req(1, 1'b1, 5'd9, 32'hCAFE_0009);
    exp_q.push_back({5'd9, 32'hCAFE_0009});
    #1;
    n_vec++;
    if ({req_ready, rf_rd_en} !== {3'b010, 1'b1}) begin
      n_miss++;
      $display("FAIL flush_late_wb: ready=%b en=%b, expected 010 1", req_ready, rf_rd_en);
    end
    cyc();
    set_req(1, 1'b0, 5'd0, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd4;
    #1;
    n_vec++;
    if (pending !== 32'h0) begin
      n_miss++;
      $display("FAIL flush_late_wb_pending: pending=%h, expected 00000000", pending);
    end
    cyc();
    iss_en = 1'b0; iss_rd = 5'd0;
    set_req(2, 1'b1, 5'd2, 32'h0000_F00D);
    #1;
    n_vec++;
    if ({req_ready, pending} !== {3'b100, 32'h0000_0010}) begin
      n_miss++;
      $display("FAIL pre_reset_grant: ready=%b pending=%h, expected 100 00000010",
               req_ready, pending);
    end
    // Reset lands before the falling edge, so no write is expected.
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, rf_rd_en, rf_rd_addr, pending} !== {3'b000, 1'b0, 5'd0, 32'h0}) begin
      n_miss++;
      $display("FAIL async_reset: ready=%b en=%b addr=%0d pending=%h, expected all 0",
               req_ready, rf_rd_en, rf_rd_addr, pending);
    end
    idle();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int m_rr;
    int w;
    logic [2:0]  mask;
    logic [2:0]  exp_ready;
    logic [4:0]  rds[3];
    logic [31:0] ds[3];
    do_reset();
    m_rr = 0;
    for (int c = 0; c < 25; c++) begin
      mask = 3'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        rds[i] = 5'($urandom_range(1, 31));
        ds[i]  = $urandom;
        set_req(i, mask[i], rds[i], ds[i]);
      end
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        if (w < 0 && mask[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
      end
      exp_ready = (w < 0) ? 3'b000 : (3'b001 << w);
      #1;
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_miss++;
        $display("FAIL b2b_grant[%0d]: ready=%b, expected %b (mask %b)",
                 c, req_ready, exp_ready, mask);
      end
      if (w >= 0) begin
        exp_q.push_back({rds[w], ds[w]});
        m_rr = (w + 1) % NREQ;
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_raw_stall();
    test_round_robin();
    test_x0_write();
    test_set_clear_same_edge();
    test_flush_and_async_reset();
    test_back_to_back();
    cyc();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL wb_missing: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
